// File: rtl/eq_answer_checker.sv
// Answer checker for the alarm game: captures the solver's answer vector, collects
// player entries one per Go press, and holds a pass/fail verdict until cleared.
module eq_answer_checker #(
    parameter int DATA_W    = 4,
    parameter int NUM_ANS   = 3,
    parameter int MAX_TRIES = 3
) (
    input  logic                      Clock,
    input  logic                      Resetn,
    input  logic                      sol_valid,
    input  logic [NUM_ANS*DATA_W-1:0] sol_data,
    output logic                      sol_ack,
    input  logic                      Go,
    input  logic [DATA_W-1:0]         data_in,
    input  logic                      clear,
    output logic [2:0]                entry_idx,
    output logic [2:0]                tries_left,
    output logic                      busy,
    output logic                      wrong,
    output logic                      correct,
    output logic                      fail
);

    // state   | meaning
    // IDLE    | waiting for a solver result
    // ENTER   | collecting player values into slot entry_idx
    // COMPARE | one cycle: entries checked against solution
    // PASS    | verdict correct, held until clear
    // FAIL    | retries exhausted, held until clear
    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        ENTER   = 3'd1,
        COMPARE = 3'd2,
        PASS    = 3'd3,
        FAIL    = 3'd4
    } state_t;

    state_t                      state;
    logic                        go_d;
    logic [NUM_ANS*DATA_W-1:0]   sol_q;
    logic [NUM_ANS*DATA_W-1:0]   ent_q;
    logic                        go_rise;
    logic                        match;

    assign go_rise = Go & ~go_d;
    assign match   = (ent_q == sol_q);

    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            state      <= IDLE;
            go_d       <= 1'b0;
            sol_q      <= '0;
            ent_q      <= '0;
            entry_idx  <= 3'd0;
            tries_left <= 3'(MAX_TRIES);
            sol_ack    <= 1'b0;
            wrong      <= 1'b0;
        end else begin
            go_d    <= Go;
            sol_ack <= 1'b0;
            wrong   <= 1'b0;
            if (clear) begin
                state      <= IDLE;
                entry_idx  <= 3'd0;
                tries_left <= 3'(MAX_TRIES);
            end else begin
                case (state)
                    IDLE: begin
                        if (sol_valid) begin
                            sol_q      <= sol_data;
                            entry_idx  <= 3'd0;
                            tries_left <= 3'(MAX_TRIES);
                            sol_ack    <= 1'b1;
                            state      <= ENTER;
                        end
                    end
                    ENTER: begin
                        if (go_rise) begin
                            for (int k = 0; k < NUM_ANS; k++) begin
                                if (entry_idx == 3'(k))
                                    ent_q[k*DATA_W +: DATA_W] <= data_in;
                            end
                            entry_idx <= entry_idx + 3'd1;
                            if (entry_idx == 3'(NUM_ANS-1))
                                state <= COMPARE;
                        end
                    end
                    COMPARE: begin
                        if (match) begin
                            state <= PASS;
                        end else if (tries_left > 3'd1) begin
                            // stale entries are kept; each retry overwrites them slot by slot
                            tries_left <= tries_left - 3'd1;
                            entry_idx  <= 3'd0;
                            wrong      <= 1'b1;
                            state      <= ENTER;
                        end else begin
                            tries_left <= 3'd0;
                            state      <= FAIL;
                        end
                    end
                    PASS:    state <= PASS;
                    FAIL:    state <= FAIL;
                    default: state <= IDLE;
                endcase
            end
        end
    end

    assign busy    = (state != IDLE);
    assign correct = (state == PASS);
    assign fail    = (state == FAIL);

endmodule

// File: tb/tb_eq_answer_checker.sv
// Directed bench for eq_answer_checker: pass, retry, lockout, held key, clear
// priority, handshake while busy and asynchronous reset abort.
module tb_eq_answer_checker;

    localparam int DATA_W    = 4;
    localparam int NUM_ANS   = 3;
    localparam int MAX_TRIES = 3;

    logic                      Clock;
    logic                      Resetn;
    logic                      sol_valid;
    logic [NUM_ANS*DATA_W-1:0] sol_data;
    logic                      sol_ack;
    logic                      Go;
    logic [DATA_W-1:0]         data_in;
    logic                      clear;
    logic [2:0]                entry_idx;
    logic [2:0]                tries_left;
    logic                      busy;
    logic                      wrong;
    logic                      correct;
    logic                      fail;

    int checks = 0;
    int errors = 0;

    // slots {z,y,x} = {1,E,3}: slot0=3, slot1=E(-2), slot2=1
    localparam logic [11:0] SOL = 12'h1E3;

    eq_answer_checker #(
        .DATA_W(DATA_W), .NUM_ANS(NUM_ANS), .MAX_TRIES(MAX_TRIES)
    ) dut (
        .Clock(Clock), .Resetn(Resetn),
        .sol_valid(sol_valid), .sol_data(sol_data), .sol_ack(sol_ack),
        .Go(Go), .data_in(data_in), .clear(clear),
        .entry_idx(entry_idx), .tries_left(tries_left),
        .busy(busy), .wrong(wrong), .correct(correct), .fail(fail)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge Clock);
        #1;
    endtask

    task automatic press(input logic [3:0] v);
        data_in = v;
        Go = 1'b1;
        step();
        Go = 1'b0;
        step();
    endtask

    task automatic load();
        sol_data  = SOL;
        sol_valid = 1'b1;
        step();
        sol_valid = 1'b0;
    endtask

    task automatic do_clear();
        clear = 1'b1;
        step();
        clear = 1'b0;
    endtask

    initial begin
        Resetn = 1'b0; sol_valid = 1'b0; sol_data = '0; Go = 1'b0;
        data_in = '0; clear = 1'b0;
        step();
        check("rst_ack",   32'(sol_ack), 0);
        check("rst_busy",  32'(busy), 0);
        check("rst_corr",  32'(correct), 0);
        check("rst_fail",  32'(fail), 0);
        check("rst_wrong", 32'(wrong), 0);
        check("rst_idx",   32'(entry_idx), 0);
        check("rst_tries", 32'(tries_left), 3);
        Resetn = 1'b1;
        step();

        // basic pass
        load();
        check("p_ack",   32'(sol_ack), 1);
        check("p_busy",  32'(busy), 1);
        check("p_idx0",  32'(entry_idx), 0);
        step();
        check("p_ack_lo", 32'(sol_ack), 0);
        press(4'h3);
        check("p_idx1", 32'(entry_idx), 1);
        press(4'hE);
        check("p_idx2", 32'(entry_idx), 2);
        data_in = 4'h1; Go = 1'b1;
        step();
        check("p_idx3",   32'(entry_idx), 3);
        check("p_corr_e", 32'(correct), 0);
        Go = 1'b0;
        step();
        check("p_corr",  32'(correct), 1);
        check("p_tries", 32'(tries_left), 3);
        check("p_wrong", 32'(wrong), 0);
        do_clear();
        check("c_busy", 32'(busy), 0);
        check("c_corr", 32'(correct), 0);

        // retry then pass
        load(); step();
        press(4'h3); press(4'h2); press(4'h1);
        check("r_wrong",  32'(wrong), 1);
        check("r_tries",  32'(tries_left), 2);
        check("r_idx",    32'(entry_idx), 0);
        check("r_corr",   32'(correct), 0);
        step();
        check("r_wrong_lo", 32'(wrong), 0);
        press(4'h3); press(4'hE); press(4'h1);
        check("r_corr2",  32'(correct), 1);
        check("r_tries2", 32'(tries_left), 2);
        do_clear();

        // lockout
        load(); step();
        press(4'h3); press(4'h2); press(4'h1);
        check("l_wrong1", 32'(wrong), 1);
        check("l_tries1", 32'(tries_left), 2);
        step();
        press(4'h3); press(4'h2); press(4'h1);
        check("l_wrong2", 32'(wrong), 1);
        check("l_tries2", 32'(tries_left), 1);
        step();
        press(4'h3); press(4'h2); press(4'h1);
        check("l_wrong3", 32'(wrong), 0);
        check("l_fail",   32'(fail), 1);
        check("l_tries0", 32'(tries_left), 0);
        press(4'h5);
        check("l_fail_h", 32'(fail), 1);
        check("l_idx_h",  32'(entry_idx), 3);
        check("l_tries_h", 32'(tries_left), 0);
        do_clear();
        check("l_clr_busy",  32'(busy), 0);
        check("l_clr_tries", 32'(tries_left), 3);
        check("l_clr_fail",  32'(fail), 0);

        // held key: one entry only
        load(); step();
        data_in = 4'h3; Go = 1'b1;
        repeat (10) step();
        Go = 1'b0;
        step();
        check("h_idx1", 32'(entry_idx), 1);
        press(4'hE);
        check("h_idx2", 32'(entry_idx), 2);
        // clear with a same-edge go_rise on the last slot
        data_in = 4'h1; Go = 1'b1; clear = 1'b1;
        step();
        clear = 1'b0; Go = 1'b0;
        check("cg_busy", 32'(busy), 0);
        check("cg_idx",  32'(entry_idx), 0);
        step();
        check("cg_busy2", 32'(busy), 0);
        check("cg_corr",  32'(correct), 0);

        // sol_valid held while busy gives no ack
        load();
        sol_valid = 1'b1;
        step();
        check("hs_ack1", 32'(sol_ack), 0);
        step();
        check("hs_ack2", 32'(sol_ack), 0);
        sol_valid = 1'b0;
        press(4'h3); press(4'hE);
        check("hs_idx", 32'(entry_idx), 2);

        // async reset mid-entry
        #2 Resetn = 1'b0;
        #1;
        check("ar_busy",  32'(busy), 0);
        check("ar_idx",   32'(entry_idx), 0);
        check("ar_tries", 32'(tries_left), 3);
        check("ar_ack",   32'(sol_ack), 0);
        Resetn = 1'b1;
        step();
        check("ar_busy2", 32'(busy), 0);
        load();
        check("ar_ack2", 32'(sol_ack), 1);
        check("ar_idx2", 32'(entry_idx), 0);
        step();
        press(4'h3); press(4'hE); press(4'h1);
        check("ar_corr", 32'(correct), 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/eq_answer_checker.md
# eq_answer_checker

Receives the solved answer vector from the equation solver and checks it against values the player keys in, one per Go press. It is the consumer end of the solver's result interface and the producer of the pass/fail verdict for the alarm game. The block tracks entry order, retry count and lockout, and holds the verdict until the top level clears it.

## Interface
- DATA_W, 4: width of one answer value, two's complement, compared bitwise.
- NUM_ANS, 3: answers per equation set; range 1..7.
- MAX_TRIES, 3: attempts allowed before lockout; range 1..7.

- Clock  in  1  system clock, rising edge.
- Resetn  in  1  asynchronous, active-low reset.
- sol_valid  in  1  solver result available; level, held until sol_ack.
- sol_data  in  NUM_ANS*DATA_W  answers; slot k at bits [k*DATA_W +: DATA_W].
- sol_ack  out  1  one-cycle pulse: sol_data captured.
- Go  in  1  player key, synchronous, active-high level; one entry per rising edge.
- data_in  in  DATA_W  player value (switches), sampled on Go rising edge.
- clear  in  1  synchronous return to IDLE from any state.
- entry_idx  out  3  index of the next slot to be entered.
- tries_left  out  3  remaining attempts.
- busy  out  1  high in every state except IDLE.
- wrong  out  1  one-cycle pulse on a failed attempt that still has retries.
- correct  out  1  level, high in PASS only.
- fail  out  1  level, high in FAIL only.

## Operation
- States: IDLE, ENTER, COMPARE, PASS, FAIL.
- go_rise = Go & ~go_d. go_d is a register of Go, reset to 0. If Go is high on the first cycle after reset, that counts as a rising edge.
- IDLE: on an edge with sol_valid=1, register sol_data, set entry_idx=0 and tries_left=MAX_TRIES, and go to ENTER. sol_ack is high for exactly the next cycle.
- ENTER: on an edge with go_rise=1, write data_in into slot entry_idx and increment entry_idx. When the written slot is NUM_ANS-1, go to COMPARE. go_rise in any other state is ignored, but go_d always tracks Go.
- COMPARE (1 cycle): match = all NUM_ANS entry slots equal the solution slots.
  - If match: go to PASS.
  - Else if tries_left > 1: decrement tries_left, set entry_idx=0, pulse wrong for 1 cycle, and go to ENTER. Old entries stay until overwritten.
  - Else: set tries_left=0 and go to FAIL.
- PASS and FAIL hold indefinitely.
- clear=1 in any state: go to IDLE next edge, with entry_idx=0 and tries_left=MAX_TRIES. clear has priority over all other transitions, including a same-cycle sol_valid and go_rise.
- sol_valid outside IDLE is ignored; sol_ack stays 0. The solver keeps sol_valid high until the ack.
- Reset values: state IDLE, sol_ack 0, wrong 0, correct 0, fail 0, busy 0, entry_idx 0, tries_left MAX_TRIES, solution and entry registers 0, go_d 0.
- Asserting Resetn low mid-entry or mid-COMPARE aborts immediately to the reset values. No verdict is produced.

## Timing
- All outputs are registered or decoded from state only. No combinational path from any input to any output.
- Latency, sol_valid to sol_ack: sol_ack is high in the cycle after the capturing edge; busy rises in the same cycle.
- Latency, last entry to verdict: on the edge capturing slot NUM_ANS-1, the state becomes COMPARE. On the next edge, correct, fail or wrong rises, so the verdict appears 2 edges after the final go_rise sample.
- Go held high gives exactly one entry; the next entry needs Go low for at least one sampled cycle.
- On a retry, wrong and ENTER are asserted in the same cycle. A go_rise in that cycle writes slot 0.

## Test plan
- Basic pass (DATA_W=4, NUM_ANS=3, MAX_TRIES=3):
  - Stimulus: sol_data slots {1,E,3} (x=3, y=-2, z=1) with sol_valid; then key 3, E, 1 into slots 0, 1, 2.
  - Required: sol_ack pulses once, entry_idx steps 0→1→2→3, correct=1 two edges after the third press, tries_left=3.
- Retry then pass:
  - Stimulus: first attempt keys 3, 2, 1; second attempt keys 3, E, 1.
  - Required: after the first attempt, wrong pulses 1 cycle, tries_left=2, entry_idx=0. After the second attempt, correct=1.
- Lockout:
  - Stimulus: three wrong attempts.
  - Required: wrong pulses twice, then fail=1 with tries_left=0. Further Go presses change nothing. clear returns to IDLE with tries_left=3 and busy=0.
- Held key and simultaneous events:
  - Stimulus: hold Go high for 10 cycles in ENTER.
  - Required: exactly one slot is written.
  - Stimulus: assert clear and go_rise on the same edge.
  - Required: IDLE, with no write.
- Handshake and reset:
  - Stimulus: sol_valid held high during ENTER.
  - Required: no sol_ack.
  - Stimulus: drive Resetn low asynchronously after 2 entries.
  - Required: all outputs go to their reset values immediately. After release, sol_valid restarts cleanly with entry_idx=0.
